// File: rtl/xregf_ctrl.sv
// Sequencer/arbiter owning the xregf control pins: zero-fills the file after
// reset or clr, then serves requesters A and B round-robin with a req/ack handshake.
module xregf_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic              a_sel,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_sel,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              rf_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);
    typedef enum logic [1:0] {CLEAR, IDLE, ACK} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              last_a;   // most recent grant went to A
    logic              grant_a, grant_b;

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        rf_sel    = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        case (state)
            CLEAR: begin
                rf_sel  = 1'b1;
                rf_we   = 1'b1;
                rf_addr = cnt;
                if (!clr && cnt == LAST) state_nxt = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                end else begin
                    // On conflict, the requester not granted last wins
                    grant_a = a_sel && (!b_sel || !last_a);
                    grant_b = b_sel && !grant_a;
                    if (grant_a) begin
                        rf_sel   = 1'b1;
                        rf_we    = a_we;
                        rf_addr  = a_addr;
                        rf_wdata = a_wdata;
                    end else if (grant_b) begin
                        rf_sel   = 1'b1;
                        rf_we    = b_we;
                        rf_addr  = b_addr;
                        rf_wdata = b_wdata;
                    end
                    if (grant_a || grant_b) state_nxt = ACK;
                end
            end
            ACK:     state_nxt = clr ? CLEAR : IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready   <= 1'b0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            last_a  <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter idles at zero so any entry into CLEAR starts at address 0
            cnt   <= (state == CLEAR && !clr) ? cnt + 1'b1 : '0;
            ready <= (state_nxt != CLEAR);
            a_ack <= grant_a;
            b_ack <= grant_b;
            if (grant_a && !a_we) a_rdata <= rf_rdata;
            if (grant_b && !b_we) b_rdata <= rf_rdata;
            if (grant_a)      last_a <= 1'b1;
            else if (grant_b) last_a <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xregf_ctrl.sv
// Bench for xregf_ctrl: register-file model plus a transaction-level reference
// predicting every output each cycle under directed and random traffic.
module tb_xregf_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, clr, ready;
    logic          a_sel, a_we, a_ack, b_sel, b_we, b_ack;
    logic [AW-1:0] a_addr, b_addr, rf_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, rf_wdata, rf_rdata;
    logic          rf_sel, rf_we;

    always #5 clk = ~clk;

    xregf_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready),
        .a_sel(a_sel), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_sel(b_sel), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_sel(rf_sel), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file environment: combinational read, write at clock edge
    logic [DW-1:0] env_mem [DEPTH];
    assign rf_rdata = env_mem[rf_addr];
    always @(posedge clk) if (rf_sel && rf_we) env_mem[rf_addr] <= rf_wdata;

    int checks = 0;
    int errors = 0;

    // Reference: clr_left = clear writes still to do, ack_who 0/1(A)/2(B)
    int            clr_left;
    int            ack_who;
    bit            last_a;
    bit            hold;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ea_rd, eb_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        clr_left = DEPTH;
        ack_who  = 0;
        last_a   = 1'b0;
        ea_rd    = '0;
        eb_rd    = '0;
    endtask

    // One clock cycle: inputs already driven; check mid-cycle, advance reference
    task automatic step();
        logic          e_sel, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, rd;
        int            grant;
        int            acked;
        #4;
        e_sel = 0; e_we = 0; e_addr = '0; e_wd = '0; grant = 0;
        acked = ack_who;
        if (clr_left > 0) begin
            e_sel = 1; e_we = 1; e_addr = AW'(DEPTH - clr_left);
        end else if (ack_who == 0 && !clr) begin
            if (a_sel && b_sel) grant = last_a ? 2 : 1;
            else if (a_sel)     grant = 1;
            else if (b_sel)     grant = 2;
            if (grant == 1) begin e_sel = 1; e_we = a_we; e_addr = a_addr; e_wd = a_wdata; end
            if (grant == 2) begin e_sel = 1; e_we = b_we; e_addr = b_addr; e_wd = b_wdata; end
        end
        chk("rf_sel", rf_sel, e_sel);
        chk("rf_we", rf_we, e_we);
        if (!(clr_left == 0 && ack_who != 0)) begin
            chk("rf_addr", rf_addr, e_addr);
            chk("rf_wdata", rf_wdata, e_wd);
        end
        chk("ready", ready, clr_left == 0);
        chk("a_ack", a_ack, ack_who == 1);
        chk("b_ack", b_ack, ack_who == 2);
        chk("a_rdata", a_rdata, ea_rd);
        chk("b_rdata", b_rdata, eb_rd);
        if (rst) begin
            reset_model();
        end else if (clr_left > 0) begin
            ref_mem[e_addr] = '0;
            clr_left = clr ? DEPTH : clr_left - 1;
        end else if (clr) begin
            clr_left = DEPTH;
            ack_who  = 0;
        end else if (ack_who != 0) begin
            ack_who = 0;
        end else if (grant != 0) begin
            rd = ref_mem[e_addr];
            if (e_we)            ref_mem[e_addr] = e_wd;
            else if (grant == 1) ea_rd = rd;
            else                 eb_rd = rd;
            ack_who = grant;
            last_a  = (grant == 1);
        end
        @(posedge clk);
        #1;
        if (!hold && acked == 1) a_sel = 1'b0;
        if (!hold && acked == 2) b_sel = 1'b0;
    endtask

    task automatic req_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_sel = 1; a_we = we; a_addr = addr; a_wdata = d;
    endtask

    task automatic req_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        b_sel = 1; b_we = we; b_addr = addr; b_wdata = d;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((a_sel || b_sel) && n < limit) begin step(); n++; end
        chk("drain_timeout", (a_sel || b_sel), 1'b0);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((clr_left != 0 || ack_who != 0) && n < limit) begin step(); n++; end
        chk("idle_timeout", (clr_left != 0 || ack_who != 0), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 32'hA5A5_0000 + DW'(i);
            ref_mem[i] = 32'hA5A5_0000 + DW'(i);
        end
        hold = 0;
        rst = 1; clr = 0;
        a_sel = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_sel = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        @(posedge clk); #1;
        reset_model();
        // B write held from reset, second reset cycle checked here
        req_b(1, 5, 32'h1);
        step();
        rst = 0;
        drain(40);
        // Every register must read back zero except addr 5
        for (int i = 0; i < DEPTH; i++) begin req_a(0, AW'(i), '0); drain(10); end
        req_a(1, 3, 32'hDEAD_BEEF); drain(10);
        req_a(0, 3, '0);            drain(10);
        req_b(0, 5, '0);            drain(10);
        // Clear takes priority over a same-cycle request
        wait_idle(10);
        req_a(0, 3, '0); clr = 1; step(); clr = 0;
        drain(40);
        // Reset in the ACK cycle of an A read, then again mid-clear at address 7
        req_a(0, 5, '0);
        wait_idle(10);
        step();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 7; i++) step();
        rst = 1; step(); rst = 0;
        a_sel = 0;
        wait_idle(40);
        // Held conflict right after reset: A first, then strict alternation
        rst = 1; step(); rst = 0;
        wait_idle(40);
        hold = 1;
        req_a(0, 1, '0); req_b(0, 2, '0);
        for (int i = 0; i < 12; i++) step();
        hold = 0;
        a_sel = 0; b_sel = 0;
        step(); step();
        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!a_sel && ($urandom % 3) == 0) req_a(1'($urandom), AW'($urandom), $urandom);
            if (!b_sel && ($urandom % 3) == 0) req_b(1'($urandom), AW'($urandom), $urandom);
            clr = (($urandom % 60) == 0);
            rst = (($urandom % 400) == 0);
            step();
        end
        rst = 0; clr = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
